branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  EX-stage counterpart of the fetch-side branch predictor. Evaluates conditional branches and JALR,
//  compares the outcome with the prediction carried down the pipe, and issues a one-cycle redirect/flush.
//  Drives the predictor training port (BHT/BTT/credit/loop updates) and keeps mispredict counters.
// PARAMETERS
//  ADDR_WIDTH    32  PC / target width
//  DATA_WIDTH    32  register operand width
//  DRAIN_CYCLES  2   wrong-path cycles ignored after a redirect (1..7)
//  CNT_WIDTH     32  width of the saturating performance counters
// PORTS
//  cpu_clk              in   1    core clock
//  cpu_rst              in   1    reset: synchronous, active-high
//  ex_stall             in   1    EX holds its instruction; no resolution this cycle
//  branch_ex            in   1    conditional branch valid in EX
//  jalr_ex              in   1    JALR valid in EX (mutually exclusive with branch_ex)
//  funct3_ex            in   3    branch condition encoding
//  branch_pc_ex         in   AW   PC of the instruction in EX
//  imm_ex               in   AW   sign-extended immediate
//  src_data1_ex/2_ex    in   DW   forwarded rs1 / rs2 operands
//  predict_taken_ex     in   1    final prediction made at fetch
//  predict_target_ex    in   AW   predicted target made at fetch
//  predict1/3_taken_ex  in   1    sub-predictor opinions made at fetch
//  is_loop_ex           in   1    loop flag made at fetch
//  redirect_valid       out  1    flush younger stages, refetch from redirect_pc
//  redirect_pc          out  AW   correct next PC
//  upd_valid            out  1    predictor write enable (conditional branches only)
//  upd_pc/upd_target    out  AW   branch PC / computed taken target
//  upd_taken            out  1    actual outcome
//  upd_predict1/3_taken out  1    echoed sub-predictor opinions for credit scoring
//  upd_is_loop          out  1    echoed loop flag
//  upd_jalr             out  1    JALR-resolved pulse (loop predictor)
//  branch_cnt/mispred_cnt out CNT_WIDTH  resolved / mispredicted totals
// BEHAVIOUR
//  - Resolve = (branch_ex|jalr_ex) & !ex_stall & state==IDLE. Every output registered, 1-cycle latency.
//  - Conditions: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 -> not taken.
//  - Branch target = pc+imm (mod 2^AW); JALR target = (rs1+imm) & ~1; JALR always taken.
//  - Mispredict = taken!=predict_taken_ex, or taken & predict_taken_ex & target!=predict_target_ex.
//  - redirect_pc = taken ? target : pc+4 (wraps at 2^AW).
//  - FSM IDLE -> REDIRECT on mispredict; REDIRECT (redirect_valid=1, one cycle) -> DRAIN;
//    DRAIN counts DRAIN_CYCLES then -> IDLE. In REDIRECT/DRAIN branch_ex/jalr_ex are wrong-path:
//    no update, no counter change, no second redirect. DRAIN_CYCLES==0 -> REDIRECT -> IDLE.
//  - Correct prediction: upd_* pulse only, state stays IDLE, redirect_valid stays 0.
//  - Stall: while ex_stall=1 nothing fires; resolution occurs exactly once, on first unstalled cycle.
//  - upd_valid is a one-cycle pulse per resolved conditional branch; upd_jalr for JALR only.
//  - Counters increment on resolve / on mispredict; saturate at all-ones, never wrap.
//  - Reset (any cycle, incl. mid-REDIRECT/DRAIN): state IDLE, drain count 0, all outputs and counters 0.
// STRUCTURE
//  - Branch funct3 encodings and FSM state encodings go in core_defines.vh; ADDR/DATA widths from there.
//  - Sub-module branch_compare: combinational condition evaluator (funct3, rs1, rs2 -> taken).
//  - Top level: target adders, mispredict compare, FSM, drain counter, output/counter registers.
// TESTING
//  - BEQ pc=0x100 imm=0x20 rs1=rs2=5, predicted taken->0x120: upd_valid, upd_taken=1, no redirect.
//  - BLT rs1=0xFFFFFFFF rs2=1, predicted not taken: redirect_valid 1 cycle, redirect_pc=pc+imm, mispred_cnt=1.
//  - BLTU same operands, predicted taken: redirect_pc=pc+4; branch in EX next 2 cycles -> no upd, no redirect.
//  - JALR rs1=0x2001 imm=2, predicted target 0x2002: upd_jalr=1, target 0x2002 match, no redirect; 0x2004 -> redirect.
//  - ex_stall held 3 cycles on mispredicting BNE: single redirect after release; reset during DRAIN -> IDLE, counts 0.
//  - Force mispred_cnt to 0xFFFFFFFF then mispredict: stays 0xFFFFFFFF; funct3=010 -> treated not taken.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared widths, branch condition encodings and FSM states for the EX-stage branch resolver.
package branch_resolve_unit_pkg;

    localparam int BRU_ADDR_WIDTH = 32;
    localparam int BRU_DATA_WIDTH = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_DRAIN    = 2'b10
    } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch bus: resolution inputs from EX, redirect/training/counter outputs back.
interface branch_resolve_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  ex_stall;
    logic                  branch_ex;
    logic                  jalr_ex;
    logic [2:0]            funct3_ex;
    logic [ADDR_WIDTH-1:0] branch_pc_ex;
    logic [ADDR_WIDTH-1:0] imm_ex;
    logic [DATA_WIDTH-1:0] src_data1_ex;
    logic [DATA_WIDTH-1:0] src_data2_ex;
    logic                  predict_taken_ex;
    logic [ADDR_WIDTH-1:0] predict_target_ex;
    logic                  predict1_taken_ex;
    logic                  predict3_taken_ex;
    logic                  is_loop_ex;

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic [ADDR_WIDTH-1:0] upd_target;
    logic                  upd_taken;
    logic                  upd_predict1_taken;
    logic                  upd_predict3_taken;
    logic                  upd_is_loop;
    logic                  upd_jalr;
    logic [CNT_WIDTH-1:0]  branch_cnt;
    logic [CNT_WIDTH-1:0]  mispred_cnt;

    modport master (
        output ex_stall, branch_ex, jalr_ex, funct3_ex, branch_pc_ex, imm_ex,
               src_data1_ex, src_data2_ex, predict_taken_ex, predict_target_ex,
               predict1_taken_ex, predict3_taken_ex, is_loop_ex,
        input  redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
               upd_predict1_taken, upd_predict3_taken, upd_is_loop, upd_jalr,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  ex_stall, branch_ex, jalr_ex, funct3_ex, branch_pc_ex, imm_ex,
               src_data1_ex, src_data2_ex, predict_taken_ex, predict_target_ex,
               predict1_taken_ex, predict3_taken_ex, is_loop_ex,
        output redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
               upd_predict1_taken, upd_predict3_taken, upd_is_loop, upd_jalr,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch condition evaluator; reserved encodings resolve as not taken.
module branch_resolve_unit_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_WIDTH = BRU_DATA_WIDTH
) (
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    output logic                  taken_o
);
    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rs1_i == rs2_i);
            F3_BNE:  taken_o = (rs1_i != rs2_i);
            F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: taken_o = (rs1_i <  rs2_i);
            F3_BGEU: taken_o = (rs1_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/JALR in EX against the fetch prediction; registered redirect, predictor
// training and saturating mispredict counters, one cycle after the unstalled resolve.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = BRU_ADDR_WIDTH,
    parameter int DATA_WIDTH   = BRU_DATA_WIDTH,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    branch_resolve_unit_if.slave bus
);
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    bru_state_e state_q, state_d;
    logic [2:0] drain_q, drain_d;

    logic                  redirect_valid_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;
    logic                  upd_valid_q;
    logic [ADDR_WIDTH-1:0] upd_pc_q;
    logic [ADDR_WIDTH-1:0] upd_target_q;
    logic                  upd_taken_q;
    logic                  upd_p1_q;
    logic                  upd_p3_q;
    logic                  upd_loop_q;
    logic                  upd_jalr_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_q;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q;

    logic                  cond_taken;
    logic                  taken;
    logic                  resolve;
    logic                  mispred;
    logic [ADDR_WIDTH-1:0] br_target;
    logic [ADDR_WIDTH-1:0] jalr_target;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc_plus4;

    branch_resolve_unit_compare #(.DATA_WIDTH(DATA_WIDTH)) u_compare (
        .funct3_i (bus.funct3_ex),
        .rs1_i    (bus.src_data1_ex),
        .rs2_i    (bus.src_data2_ex),
        .taken_o  (cond_taken)
    );

    // Anything arriving while REDIRECT/DRAIN is on the flushed wrong path.
    assign resolve     = (bus.branch_ex | bus.jalr_ex) & ~bus.ex_stall & (state_q == ST_IDLE);
    assign taken       = bus.jalr_ex | cond_taken;
    assign br_target   = bus.branch_pc_ex + bus.imm_ex;
    assign jalr_target = (ADDR_WIDTH'(bus.src_data1_ex) + bus.imm_ex) & ~ADDR_WIDTH'(1);
    assign target      = bus.jalr_ex ? jalr_target : br_target;
    assign pc_plus4    = bus.branch_pc_ex + ADDR_WIDTH'(4);
    assign mispred     = (taken != bus.predict_taken_ex) ||
                         (taken && bus.predict_taken_ex && (target != bus.predict_target_ex));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (resolve && mispred) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                drain_d = 3'd0;
                state_d = (DRAIN_CYCLES == 0) ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    drain_d = 3'd0;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drain_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q          <= ST_IDLE;
            drain_q          <= 3'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_target_q     <= '0;
            upd_taken_q      <= 1'b0;
            upd_p1_q         <= 1'b0;
            upd_p3_q         <= 1'b0;
            upd_loop_q       <= 1'b0;
            upd_jalr_q       <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            drain_q          <= drain_d;
            redirect_valid_q <= resolve & mispred;
            upd_valid_q      <= resolve & bus.branch_ex;
            upd_jalr_q       <= resolve & bus.jalr_ex;
            if (resolve) begin
                redirect_pc_q <= taken ? target : pc_plus4;
                upd_pc_q      <= bus.branch_pc_ex;
                upd_target_q  <= target;
                upd_taken_q   <= taken;
                upd_p1_q      <= bus.predict1_taken_ex;
                upd_p3_q      <= bus.predict3_taken_ex;
                upd_loop_q    <= bus.is_loop_ex;
                if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
                if (mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.redirect_valid     = redirect_valid_q;
    assign bus.redirect_pc        = redirect_pc_q;
    assign bus.upd_valid          = upd_valid_q;
    assign bus.upd_pc             = upd_pc_q;
    assign bus.upd_target         = upd_target_q;
    assign bus.upd_taken          = upd_taken_q;
    assign bus.upd_predict1_taken = upd_p1_q;
    assign bus.upd_predict3_taken = upd_p3_q;
    assign bus.upd_is_loop        = upd_loop_q;
    assign bus.upd_jalr           = upd_jalr_q;
    assign bus.branch_cnt         = branch_cnt_q;
    assign bus.mispred_cnt        = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected responses, a monitor pops on output.
module tb_branch_resolve_unit;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    branch_resolve_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRAIN_CYCLES(2), .CNT_WIDTH(CW)
    ) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus)
    );

    typedef struct {
        logic          rv;
        logic [31:0]   rpc;
        logic          uv;
        logic          ut;
        logic [31:0]   upc;
        logic [31:0]   utgt;
        logic          uj;
        logic [2:0]    opin;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t exp_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [CW-1:0] sat(input int x);
        return (x > 15) ? 4'hF : CW'(x);
    endfunction

    task automatic idle_inputs();
        bus.ex_stall          = 1'b0;
        bus.branch_ex         = 1'b0;
        bus.jalr_ex           = 1'b0;
        bus.funct3_ex         = 3'b000;
        bus.branch_pc_ex      = '0;
        bus.imm_ex            = '0;
        bus.src_data1_ex      = '0;
        bus.src_data2_ex      = '0;
        bus.predict_taken_ex  = 1'b0;
        bus.predict_target_ex = '0;
        bus.predict1_taken_ex = 1'b0;
        bus.predict3_taken_ex = 1'b0;
        bus.is_loop_ex        = 1'b0;
    endtask

    task automatic set_vec(input logic jalr, input logic [2:0] f3, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic pt, input logic [31:0] ptgt, input logic [2:0] opin);
        bus.branch_ex         = ~jalr;
        bus.jalr_ex           = jalr;
        bus.funct3_ex         = f3;
        bus.branch_pc_ex      = pc;
        bus.imm_ex            = imm;
        bus.src_data1_ex      = rs1;
        bus.src_data2_ex      = rs2;
        bus.predict_taken_ex  = pt;
        bus.predict_target_ex = ptgt;
        bus.predict1_taken_ex = opin[2];
        bus.predict3_taken_ex = opin[1];
        bus.is_loop_ex        = opin[0];
    endtask

    task automatic push(input logic rv, input logic [31:0] rpc, input logic uv, input logic ut,
                        input logic [31:0] upc, input logic [31:0] utgt, input logic uj,
                        input logic [2:0] opin, input logic [CW-1:0] bc, input logic [CW-1:0] mc);
        exp_t e;
        e.rv = rv; e.rpc = rpc; e.uv = uv; e.ut = ut; e.upc = upc; e.utgt = utgt;
        e.uj = uj; e.opin = opin; e.bc = bc; e.mc = mc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mispredicting branches presented while the pipe is flushing must be ignored.
    task automatic wrong_path(input int n);
        for (int i = 0; i < n; i++) begin
            set_vec(1'b0, 3'b000, 32'hBAD0, 32'h40, 32'd9, 32'd9, 1'b0, 32'h0, 3'b111);
            tick();
        end
        idle_inputs();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.redirect_valid || bus.upd_valid || bus.upd_jalr)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: rv=%0b uv=%0b uj=%0b with no expectation at %0t",
                             bus.redirect_valid, bus.upd_valid, bus.upd_jalr, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
                    if (e.rv) chk("redirect_pc", bus.redirect_pc, e.rpc);
                    chk("upd_valid", 32'(bus.upd_valid), 32'(e.uv));
                    chk("upd_jalr", 32'(bus.upd_jalr), 32'(e.uj));
                    chk("upd_taken", 32'(bus.upd_taken), 32'(e.ut));
                    chk("upd_pc", bus.upd_pc, e.upc);
                    chk("upd_target", bus.upd_target, e.utgt);
                    chk("upd_opinions", 32'({bus.upd_predict1_taken, bus.upd_predict3_taken, bus.upd_is_loop}),
                        32'(e.opin));
                    chk("branch_cnt", 32'(bus.branch_cnt), 32'(e.bc));
                    chk("mispred_cnt", 32'(bus.mispred_cnt), 32'(e.mc));
                end
            end
        end
    end

    initial begin : stimulus
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("reset_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("reset_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("reset_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // BEQ correctly predicted taken
        push(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h120, 1'b0, 3'b101, 4'd1, 4'd0);
        set_vec(1'b0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120, 3'b101);
        tick(); idle_inputs(); tick();

        // BLT signed -1 < 1, predicted not taken
        push(1'b1, 32'h240, 1'b1, 1'b1, 32'h200, 32'h240, 1'b0, 3'b010, 4'd2, 4'd1);
        set_vec(1'b0, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 3'b010);
        tick(); wrong_path(3);

        // BLTU 0xFFFFFFFF < 1 false, predicted taken
        push(1'b1, 32'h304, 1'b1, 1'b0, 32'h300, 32'h310, 1'b0, 3'b001, 4'd3, 4'd2);
        set_vec(1'b0, 3'b110, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h310, 3'b001);
        tick(); wrong_path(3);

        // JALR target (0x2001+2)&~1 = 0x2002, predicted correctly
        push(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 32'h2002, 1'b1, 3'b000, 4'd4, 4'd2);
        set_vec(1'b1, 3'b000, 32'h400, 32'h2, 32'h2001, 32'h0, 1'b1, 32'h2002, 3'b000);
        tick(); idle_inputs(); tick();

        // JALR with wrong predicted target
        push(1'b1, 32'h2002, 1'b0, 1'b1, 32'h404, 32'h2002, 1'b1, 3'b100, 4'd5, 4'd3);
        set_vec(1'b1, 3'b000, 32'h404, 32'h2, 32'h2001, 32'h0, 1'b1, 32'h2004, 3'b100);
        tick(); wrong_path(3);

        // BNE held under stall for 3 cycles, then released once
        push(1'b1, 32'h4F0, 1'b1, 1'b1, 32'h500, 32'h4F0, 1'b0, 3'b011, 4'd6, 4'd4);
        set_vec(1'b0, 3'b001, 32'h500, 32'hFFFF_FFF0, 32'd1, 32'd2, 1'b0, 32'h0, 3'b011);
        bus.ex_stall = 1'b1;
        repeat (3) tick();
        bus.ex_stall = 1'b0;
        tick(); idle_inputs();
        tick();
        // now in DRAIN: reset here
        rst = 1'b1;
        tick();
        chk("drain_reset_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("drain_reset_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("drain_reset_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("drain_reset_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
        rst = 1'b0;

        // Must resolve immediately: state went back to IDLE
        push(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h608, 1'b0, 3'b110, 4'd1, 4'd0);
        set_vec(1'b0, 3'b000, 32'h600, 32'h8, 32'd1, 32'd2, 1'b0, 32'h0, 3'b110);
        tick(); idle_inputs(); tick();

        // Reserved funct3 010 is never taken
        push(1'b1, 32'h704, 1'b1, 1'b0, 32'h700, 32'h708, 1'b0, 3'b000, 4'd2, 4'd1);
        set_vec(1'b0, 3'b010, 32'h700, 32'h8, 32'd3, 32'd3, 1'b1, 32'h708, 3'b000);
        tick(); wrong_path(3);

        push(1'b0, 32'h0, 1'b1, 1'b0, 32'h710, 32'h718, 1'b0, 3'b000, 4'd3, 4'd1);
        set_vec(1'b0, 3'b011, 32'h710, 32'h8, 32'd3, 32'd3, 1'b0, 32'h0, 3'b000);
        tick(); idle_inputs(); tick();

        // Drive both counters into saturation
        for (int k = 1; k <= 16; k++) begin
            push(1'b1, 32'h804, 1'b1, 1'b1, 32'h800, 32'h804, 1'b0, 3'b000, sat(3 + k), sat(1 + k));
            set_vec(1'b0, 3'b000, 32'h800, 32'h4, 32'd7, 32'd7, 1'b0, 32'h0, 3'b000);
            tick(); wrong_path(3);
        end

        push(1'b0, 32'h0, 1'b1, 1'b1, 32'h900, 32'h910, 1'b0, 3'b000, 4'hF, 4'hF);
        set_vec(1'b0, 3'b101, 32'h900, 32'h10, 32'd4, 32'd4, 1'b1, 32'h910, 3'b000);
        tick(); idle_inputs();
        repeat (4) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
